// File: rtl/seq_scan_pkg.sv
// Shared FSM state encoding and constants for the serial pattern scanner.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [3:0]  DEFAULT_PATTERN = 4'b1101;
  localparam logic [15:0] FIRST_NONE      = 16'hFFFF;
  localparam logic [15:0] IDX_MAX         = 16'hFFFE;

endpackage

// File: rtl/seq_det_core.sv
// 4-bit history window and pattern compare for the serial scanner.
// SEQ_SCAN_OVERLAP_EN keeps history after a match; otherwise it restarts.
module seq_det_core
  import seq_scan_pkg::*;
#(
  parameter logic [3:0] PATTERN = DEFAULT_PATTERN
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_in,
  input  logic bit_en,
  input  logic clr,
  output logic match
);

  logic [2:0] hist;
  logic [1:0] nvalid;

  // nvalid==3 means three older bits are valid, so the window with bit_in is full.
  assign match = bit_en && (nvalid == 2'd3) && ({hist, bit_in} == PATTERN);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      hist   <= '0;
      nvalid <= '0;
    end else if (bit_en) begin
`ifdef SEQ_SCAN_OVERLAP_EN
      hist <= {hist[1:0], bit_in};
      if (nvalid != 2'd3) nvalid <= nvalid + 2'd1;
`else
      if (match) begin
        hist   <= '0;
        nvalid <= '0;
      end else begin
        hist <= {hist[1:0], bit_in};
        if (nvalid != 2'd3) nvalid <= nvalid + 2'd1;
      end
`endif
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-in, frame-result-out serial pattern scanner with match count and first index.
// Build option SEQ_SCAN_OVERLAP_EN selects overlapping detection in seq_det_core.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter logic [3:0] PATTERN = DEFAULT_PATTERN,
  parameter int         WORD_W  = 8,
  parameter int         CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic [15:0]       out_first,
  output logic              match_pulse
);

  localparam int             BC_W    = $clog2(WORD_W);
  localparam logic [BC_W-1:0] BC_LOAD = BC_W'(WORD_W - 1);

  state_t            state, state_nx;
  logic [WORD_W-1:0] word;
  logic              last;
  logic [BC_W-1:0]   bits_left;
  logic [15:0]       idx;
  logic              shift_en, load, take, match;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    shift_en  = 1'b0;
    load      = 1'b0;
    take      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (bits_left == '0) state_nx = last ? REPORT : IDLE;
      end
      REPORT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          take     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  seq_det_core #(.PATTERN(PATTERN)) u_det (
    .clk    (clk),
    .reset  (reset),
    .bit_in (word[WORD_W-1]),
    .bit_en (shift_en),
    .clr    (take),
    .match  (match)
  );

  // idx is the frame position of the bit currently at word[MSB].
  always_ff @(posedge clk) begin
    if (reset) begin
      word        <= '0;
      last        <= 1'b0;
      bits_left   <= '0;
      idx         <= '0;
      out_count   <= '0;
      out_first   <= FIRST_NONE;
      match_pulse <= 1'b0;
    end else begin
      match_pulse <= match;
      if (load) begin
        word      <= in_data;
        last      <= in_last;
        bits_left <= BC_LOAD;
      end
      if (shift_en) begin
        word      <= {word[WORD_W-2:0], 1'b0};
        bits_left <= bits_left - BC_W'(1);
        if (idx != IDX_MAX) idx <= idx + 16'd1;
      end
      if (match) begin
        if (out_count != '1)         out_count <= out_count + CNT_W'(1);
        if (out_first == FIRST_NONE) out_first <= idx;
      end
      if (take) begin
        out_count <= '0;
        out_first <= FIRST_NONE;
        idx       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench: directed and random frames against a bit-list reference model.
module tb_seq_scan_ctrl;
  import seq_scan_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_last, out_ready;
  logic [7:0]  in_data;
  logic        in_ready, out_valid, match_pulse;
  logic [7:0]  out_count;
  logic [15:0] out_first;
  logic        in_ready_s, out_valid_s, match_pulse_s;
  logic [1:0]  out_count_s;
  logic [15:0] out_first_s;

  int checks = 0, failures = 0;
  int pulses = 0, pulse_base = 0;
  bit frame_bits[$];

  always #5 clk = ~clk;

  seq_scan_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count), .out_first(out_first),
    .match_pulse(match_pulse)
  );

  seq_scan_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_count(out_count_s), .out_first(out_first_s),
    .match_pulse(match_pulse_s)
  );

  always @(posedge clk) if (match_pulse) pulses <= pulses + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: scan the frame's bit list for 4-bit windows equal to the pattern.
  task automatic model(output int cnt, output int first);
    int last_end = -100;
    bit [3:0] w;
    cnt = 0;
    first = -1;
    for (int i = 3; i < frame_bits.size(); i++) begin
      w = {frame_bits[i-3], frame_bits[i-2], frame_bits[i-1], frame_bits[i]};
`ifdef SEQ_SCAN_OVERLAP_EN
      if (w == DEFAULT_PATTERN) begin
`else
      if (w == DEFAULT_PATTERN && i - last_end >= 4) begin
`endif
        cnt++;
        if (first < 0) first = i;
        last_end = i;
      end
    end
  endtask

  task automatic start_frame();
    frame_bits.delete();
    pulse_base = pulses;
  endtask

  task automatic send_word(input logic [7:0] d, input logic l);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int i = 7; i >= 0; i--) frame_bits.push_back(d[i]);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic end_frame(input string tag, input int ready_delay);
    int cnt, first;
    model(cnt, first);
    wait_valid();
    repeat (ready_delay) @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_in_ready_rep"}, in_ready, 0);
    check({tag, "_count"}, out_count, (cnt > 255) ? 255 : cnt);
    check({tag, "_first"}, out_first, (first < 0) ? 32'hFFFF : first);
    check({tag, "_count_sat"}, out_count_s, (cnt > 3) ? 3 : cnt);
    check({tag, "_first_sat"}, out_first_s, (first < 0) ? 32'hFFFF : first);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_idle"}, in_ready, 1);
    check({tag, "_pulses"}, pulses - pulse_base, cnt);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_count"}, out_count, 0);
    check({tag, "_first"}, out_first, 16'hFFFF);
    check({tag, "_pulse"}, match_pulse, 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_state("rst");

    start_frame(); send_word(8'b1101_0000, 1'b1); end_frame("one_word", 0);
    start_frame(); send_word(8'b1101_1010, 1'b1); end_frame("overlap", 0);
    start_frame(); send_word(8'b0000_0011, 1'b0); send_word(8'b0100_0000, 1'b1);
    end_frame("span", 0);

    start_frame(); send_word(8'b1101_0000, 1'b1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_count", out_count, 1);
      check("hold_first", out_first, 3);
    end
    end_frame("hold", 0);

    start_frame(); send_word(8'b1101_1101, 1'b1);
    repeat (4) @(negedge clk);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    check_reset_state("rst_shift");
    start_frame(); send_word(8'h00, 1'b1); end_frame("after_rst", 0);

    start_frame(); send_word(8'b1101_0000, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    start_frame(); send_word(8'h80, 1'b1); end_frame("hist_clr", 0);

    start_frame(); send_word(8'b1101_0000, 1'b1);
    wait_valid();
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    check_reset_state("rst_report");

    start_frame(); send_word(8'b1101_1101, 1'b0); send_word(8'b1101_1101, 1'b1);
    end_frame("sat", 0);

    for (int f = 0; f < 30; f++) begin
      int nw = $urandom_range(1, 3);
      start_frame();
      for (int w = 0; w < nw; w++)
        send_word(8'($urandom_range(0, 255)), (w == nw - 1));
      end_frame("rand", $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
